dcache_mshr: RTL
================

DCACHE_MSHR -- requirements
Module: dcache_mshr

Interface
REQ-001 Parameter MSHR_DEPTH, 16, number of entries (power of two, 2..64).
REQ-002 Parameter ADDR_W, 32, request address width.
REQ-003 Parameter MEM_TAG_W, 4, memory transaction tag width; tag 0 means "none".
REQ-004 Parameter SET_W, 3, cache set index width.
REQ-005 Parameter WAY_W, 2, cache way index width.
REQ-006 Parameter ROB_IDX_W, 5, ROB index width.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-008 clock  in  1  rising-edge clock.
REQ-009 reset  in  1  asynchronous active-high reset.
REQ-010 alloc_valid  in  1  miss request present.
REQ-011 alloc_addr / alloc_set / alloc_way / alloc_rob_idx  in  ADDR_W / SET_W / WAY_W / ROB_IDX_W  miss address, fill set, victim way, ROB index.
REQ-012 alloc_ready  out  1  entry available.
REQ-013 Dcache2mem_command  out  2  0 = BUS_NONE, 1 = BUS_LOAD.
REQ-014 Dcache2mem_addr  out  ADDR_W  block address, low 3 bits zero.
REQ-015 mem2Dcache_response  in  MEM_TAG_W  same-cycle acceptance tag; 0 = rejected.
REQ-016 mem2Dcache_data / mem2Dcache_tag  in  64 / MEM_TAG_W  returning block and its tag.
REQ-017 fill_valid  out  1  head entry complete.
REQ-018 fill_addr / fill_data / fill_set / fill_way / fill_rob_idx  out  ADDR_W / 64 / SET_W / WAY_W / ROB_IDX_W  completed entry fields.
REQ-019 fill_ready  in  1  consumer accepts the fill.

Function
REQ-020 Circular buffer with head, send and tail pointers, each wrapping MSHR_DEPTH-1 -> 0; occupancy counter 0..MSHR_DEPTH.
REQ-021 alloc_ready = (count < MSHR_DEPTH); a retire in the same cycle does not make a full buffer accept.
REQ-022 alloc_valid && alloc_ready writes the tail entry (valid=1, sent=0, done=0, mem_tag=0) and advances tail, taking effect next cycle.
REQ-023 Send is in order: Dcache2mem_command = BUS_LOAD when the send entry is valid and not sent; otherwise BUS_NONE, and address 0.
REQ-024 If mem2Dcache_response != 0 while BUS_LOAD is driven, the entry stores that tag, sets sent, and send advances; if the response is 0, the same request is retried next cycle.
REQ-025 mem2Dcache_tag != 0 completes every valid, sent, not-done entry whose mem_tag equals it (done=1, data captured); completion is out of order.
REQ-026 fill_valid = head valid && done; fill_* come combinationally from the head entry; all fill_* outputs are 0 when fill_valid is 0.
REQ-027 fill_valid && fill_ready invalidates the head, advances head and decrements the count; fill_valid stays held with stable data until accepted.
REQ-028 Allocate, send, completion and retire in the same cycle all take effect; the count changes by +1, -1 or 0.
REQ-029 Data returning in the same cycle as its tag acceptance cannot occur; the block need not handle it.
REQ-030 Complete latency: data captured on edge N gives fill_valid in cycle N+1 if the entry is at the head.

Reset
REQ-031 Reset clears all entry valid bits, the pointers and the count; outputs read BUS_NONE, fill_valid=0, alloc_ready=1.
REQ-032 Reset mid-operation abandons all outstanding tags; later returns match no entry and are ignored.

Configuration
REQ-033 Macro DCACHE_MSHR_MERGE_EN: when defined, an allocation whose alloc_addr[ADDR_W-1:3] matches a valid, not-done entry is written with merged=1 and sent=1 and issues no memory request; a send pointer reaching it skips it in the same cycle. On completion, a merged entry completes together with a matching entry, with the same data. An allocation that matches an entry completing in the same cycle becomes a primary and is not merged.
REQ-034 Without DCACHE_MSHR_MERGE_EN, every allocation issues its own BUS_LOAD; no merged state exists.

Verification
REQ-035 Single miss: alloc 0x1008, response 3; two cycles later tag 3 with data 0xA5 -> fill_valid with fill_addr 0x1008, fill_data 0xA5, retired on fill_ready.
REQ-036 Out-of-order return: allocate A (tag 1) then B (tag 2); tag 2 returns first -> B is done, fill_valid stays 0 until tag 1 returns, then A fills, then B.
REQ-037 Full: 16 allocations without returns -> alloc_ready=0; alloc+retire in the same cycle -> allocation refused, count 15 next cycle.
REQ-038 Retry: mem2Dcache_response=0 for 3 cycles -> BUS_LOAD held with the same address; accepted on cycle 4; send advances once.
REQ-039 Merge (macro on): allocate 0x2000 and 0x2004 -> one BUS_LOAD; tag return fills both in order with the same data; macro off -> two BUS_LOADs.
REQ-040 Reset while 3 requests are outstanding -> fill_valid=0, count 0; stale tag returns after reset produce no fill.

Source files
------------

// File: rtl/dcache_mshr_if.sv
// Bundle of the miss-request, memory-bus and fill signals of the data-cache MSHR.
// The slave modport is the MSHR side; the master modport is the cache/memory side.
interface dcache_mshr_if #(
  parameter int ADDR_W    = 32,
  parameter int MEM_TAG_W = 4,
  parameter int SET_W     = 3,
  parameter int WAY_W     = 2,
  parameter int ROB_IDX_W = 5
);
  logic                 alloc_valid;
  logic [ADDR_W-1:0]    alloc_addr;
  logic [SET_W-1:0]     alloc_set;
  logic [WAY_W-1:0]     alloc_way;
  logic [ROB_IDX_W-1:0] alloc_rob_idx;
  logic                 alloc_ready;

  logic [1:0]           Dcache2mem_command;
  logic [ADDR_W-1:0]    Dcache2mem_addr;
  logic [MEM_TAG_W-1:0] mem2Dcache_response;
  logic [63:0]          mem2Dcache_data;
  logic [MEM_TAG_W-1:0] mem2Dcache_tag;

  logic                 fill_valid;
  logic [ADDR_W-1:0]    fill_addr;
  logic [63:0]          fill_data;
  logic [SET_W-1:0]     fill_set;
  logic [WAY_W-1:0]     fill_way;
  logic [ROB_IDX_W-1:0] fill_rob_idx;
  logic                 fill_ready;

  modport slave (
    input  alloc_valid, alloc_addr, alloc_set, alloc_way, alloc_rob_idx,
    output alloc_ready,
    output Dcache2mem_command, Dcache2mem_addr,
    input  mem2Dcache_response, mem2Dcache_data, mem2Dcache_tag,
    output fill_valid, fill_addr, fill_data, fill_set, fill_way, fill_rob_idx,
    input  fill_ready
  );

  modport master (
    output alloc_valid, alloc_addr, alloc_set, alloc_way, alloc_rob_idx,
    input  alloc_ready,
    input  Dcache2mem_command, Dcache2mem_addr,
    output mem2Dcache_response, mem2Dcache_data, mem2Dcache_tag,
    input  fill_valid, fill_addr, fill_data, fill_set, fill_way, fill_rob_idx,
    output fill_ready
  );
endinterface

// File: rtl/dcache_mshr.sv
// Data-cache MSHR: circular buffer issuing misses in order, completing out of order, retiring in order.
// Optional feature: define DCACHE_MSHR_MERGE_EN to merge misses to an already outstanding block.
module dcache_mshr #(
  parameter int MSHR_DEPTH = 16,
  parameter int ADDR_W     = 32,
  parameter int MEM_TAG_W  = 4,
  parameter int SET_W      = 3,
  parameter int WAY_W      = 2,
  parameter int ROB_IDX_W  = 5
) (
  input  logic         clock,
  input  logic         reset,
  dcache_mshr_if.slave bus
);
  localparam int PTR_W = $clog2(MSHR_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MSHR_DEPTH);

  typedef enum logic [1:0] {
    BUS_NONE = 2'd0,
    BUS_LOAD = 2'd1
  } bus_cmd_e;

  logic [MSHR_DEPTH-1:0] r_valid, r_sent, r_done;
  logic [MEM_TAG_W-1:0]  r_tag  [MSHR_DEPTH];
  logic [ADDR_W-1:0]     r_addr [MSHR_DEPTH];
  logic [SET_W-1:0]      r_set  [MSHR_DEPTH];
  logic [WAY_W-1:0]      r_way  [MSHR_DEPTH];
  logic [ROB_IDX_W-1:0]  r_rob  [MSHR_DEPTH];
  logic [63:0]           r_data [MSHR_DEPTH];
  logic [PTR_W-1:0]      r_head, r_send, r_tail;
  logic [CNT_W-1:0]      r_count, r_unsent;

  logic                  w_alloc, w_alloc_merge, w_send_req, w_send_acc, w_skip;
  logic                  w_send_adv, w_fill_valid, w_retire;
  logic [MSHR_DEPTH-1:0] w_cmpl, w_mcmpl;

  assign bus.alloc_ready = (r_count != FULL_CNT);
  assign w_alloc         = bus.alloc_valid && bus.alloc_ready;

  // r_unsent counts entries between send and tail, so send==tail is never ambiguous.
  assign w_send_req = (r_unsent != '0) && !r_sent[r_send];
  assign w_send_acc = w_send_req && (bus.mem2Dcache_response != '0);
  assign w_send_adv = w_send_acc || w_skip;

  assign bus.Dcache2mem_command = w_send_req ? BUS_LOAD : BUS_NONE;
  assign bus.Dcache2mem_addr    = w_send_req ? {r_addr[r_send][ADDR_W-1:3], 3'b000} : '0;

  always_comb begin
    w_cmpl = '0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      w_cmpl[i] = (bus.mem2Dcache_tag != '0) && r_valid[i] && r_sent[i] && !r_done[i] &&
                  (r_tag[i] == bus.mem2Dcache_tag);
    end
  end

`ifdef DCACHE_MSHR_MERGE_EN
  logic [MSHR_DEPTH-1:0] r_merged;

  // Merged entries carry no tag; they finish alongside any completing entry of the same block.
  always_comb begin
    w_mcmpl = '0;
    for (int j = 0; j < MSHR_DEPTH; j++) begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        if (r_valid[j] && r_merged[j] && !r_done[j] && w_cmpl[i] &&
            (r_addr[j][ADDR_W-1:3] == r_addr[i][ADDR_W-1:3])) begin
          w_mcmpl[j] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_alloc_merge = 1'b0;
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (r_valid[i] && !r_done[i] && !w_cmpl[i] && !w_mcmpl[i] &&
          (r_addr[i][ADDR_W-1:3] == bus.alloc_addr[ADDR_W-1:3])) begin
        w_alloc_merge = 1'b1;
      end
    end
    w_alloc_merge = w_alloc_merge && w_alloc;
  end

  assign w_skip = (r_unsent != '0) && r_merged[r_send];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_merged <= '0;
    end else if (w_alloc) begin
      r_merged[r_tail] <= w_alloc_merge;
    end
  end
`else
  assign w_mcmpl       = '0;
  assign w_alloc_merge = 1'b0;
  assign w_skip        = 1'b0;
`endif

  assign w_fill_valid     = r_valid[r_head] && r_done[r_head];
  assign w_retire         = w_fill_valid && bus.fill_ready;
  assign bus.fill_valid   = w_fill_valid;
  assign bus.fill_addr    = w_fill_valid ? r_addr[r_head] : '0;
  assign bus.fill_data    = w_fill_valid ? r_data[r_head] : 64'd0;
  assign bus.fill_set     = w_fill_valid ? r_set[r_head]  : '0;
  assign bus.fill_way     = w_fill_valid ? r_way[r_head]  : '0;
  assign bus.fill_rob_idx = w_fill_valid ? r_rob[r_head]  : '0;

  // Control state: only this needs reset, payload below is qualified by r_valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid  <= '0;
      r_sent   <= '0;
      r_done   <= '0;
      r_head   <= '0;
      r_send   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_unsent <= '0;
    end else begin
      for (int i = 0; i < MSHR_DEPTH; i++) begin
        if (w_cmpl[i] || w_mcmpl[i]) r_done[i] <= 1'b1;
      end
      if (w_send_acc) r_sent[r_send] <= 1'b1;
      if (w_send_adv) r_send <= r_send + 1'b1;
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail] <= 1'b1;
        r_sent[r_tail]  <= w_alloc_merge;
        r_done[r_tail]  <= 1'b0;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_alloc && !w_retire)      r_count <= r_count + 1'b1;
      else if (!w_alloc && w_retire) r_count <= r_count - 1'b1;
      if (w_alloc && !w_send_adv)      r_unsent <= r_unsent + 1'b1;
      else if (!w_alloc && w_send_adv) r_unsent <= r_unsent - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < MSHR_DEPTH; i++) begin
      if (w_cmpl[i] || w_mcmpl[i]) r_data[i] <= bus.mem2Dcache_data;
    end
    if (w_send_acc) r_tag[r_send] <= bus.mem2Dcache_response;
    if (w_alloc) begin
      r_tag[r_tail]  <= '0;
      r_addr[r_tail] <= bus.alloc_addr;
      r_set[r_tail]  <= bus.alloc_set;
      r_way[r_tail]  <= bus.alloc_way;
      r_rob[r_tail]  <= bus.alloc_rob_idx;
    end
  end
endmodule
